hex_word_to_text: RTL and testbench

Parametrised successor to the single-nibble hex glyph lookup. It accepts a DATA_WIDTH-bit word over a valid/ready handshake and streams its hex digits as OSD font character codes, one per handshake, MSB nibble first. Optional leading-zero blanking is latched per word. It sits between debug/status registers and the OSD text-line writer.

---
 rtl/hex_text_pkg.sv | 25 ++
 rtl/hex_nibble_char.sv | 14 +
 rtl/hex_word_to_text.sv | 135 +++++++++++++
 tb/tb_hex_word_to_text.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_text_pkg.sv
// Shared font constants, FSM state type and nibble-to-glyph helper
// for the hex word to OSD text converter.
package hex_text_pkg;

   localparam logic [7:0] DEF_CHAR_ZERO  = 8'd16;
   localparam logic [7:0] DEF_CHAR_A     = 8'd33;
   localparam logic [7:0] DEF_CHAR_BLANK = 8'd0;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   function automatic logic [7:0] nibble_to_char(
      input logic [3:0] nibble,
      input logic [7:0] zero_code,
      input logic [7:0] a_code
   );
      if (nibble < 4'd10)
         return zero_code + {4'd0, nibble};
      else
         return a_code + {4'd0, nibble - 4'd10};
   endfunction

endpackage

// File: rtl/hex_nibble_char.sv
// Combinational lookup from one hex nibble to its OSD font character code.
module hex_nibble_char
   import hex_text_pkg::*;
#(
   parameter logic [7:0] CHAR_ZERO = DEF_CHAR_ZERO,
   parameter logic [7:0] CHAR_A    = DEF_CHAR_A
) (
   input  logic [3:0] nibble,
   output logic [7:0] char_code
);

   assign char_code = nibble_to_char(nibble, CHAR_ZERO, CHAR_A);

endmodule

// File: rtl/hex_word_to_text.sv
// Streams the hex digits of a handshaked word as OSD font codes, MSB nibble
// first, with optional per-word leading-zero blanking.
module hex_word_to_text
   import hex_text_pkg::*;
#(
   parameter int         DATA_WIDTH = 16,
   parameter logic [7:0] CHAR_ZERO  = DEF_CHAR_ZERO,
   parameter logic [7:0] CHAR_A     = DEF_CHAR_A,
   parameter logic [7:0] CHAR_BLANK = DEF_CHAR_BLANK
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_blank,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_char,
   output logic                  out_last
);

   localparam int NIBBLES = (DATA_WIDTH + 3) / 4;
   localparam int WORD_W  = NIBBLES * 4;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LOAD = IDX_W'((NIBBLES > 1) ? NIBBLES - 2 : 0);
   localparam logic SINGLE = (NIBBLES == 1);

   state_t            state_q, state_d;
   logic [WORD_W-1:0] word_q;
   logic [WORD_W-1:0] ext_in;
   logic [IDX_W-1:0]  idx_q;
   logic              blank_q;
   logic              seen_q;

   logic              accept;
   logic              advance;
   logic              last_hs;
   logic [3:0]        cur_nibble;
   logic [3:0]        sel_nibble;
   logic              sel_blank;
   logic              sel_seen;
   logic              sel_last;
   logic              next_seen;
   logic [7:0]        digit_char;
   logic [7:0]        next_char;

   assign ext_in  = WORD_W'(in_data);
   assign accept  = in_valid && in_ready;
   assign last_hs = out_valid && out_last && out_ready;
   assign advance = out_valid && out_ready && !out_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = EMIT;
         EMIT: if (last_hs) state_d = accept ? EMIT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Accepting on the final handshake of the previous word avoids a bubble.
   always_comb begin
      in_ready = !reset && ((state_q == IDLE) || last_hs);
   end

   always_comb begin
      cur_nibble = 4'd0;
      for (int i = 0; i < NIBBLES; i++)
         if (idx_q == IDX_W'(i)) cur_nibble = word_q[i*4 +: 4];
   end

   // A new word feeds its top nibble straight through so the first glyph lands one edge after accept.
   always_comb begin
      if (accept) begin
         sel_nibble = ext_in[WORD_W-1 -: 4];
         sel_blank  = in_blank;
         sel_seen   = 1'b0;
         sel_last   = SINGLE;
      end else begin
         sel_nibble = cur_nibble;
         sel_blank  = blank_q;
         sel_seen   = seen_q;
         sel_last   = (idx_q == '0);
      end
   end

   hex_nibble_char #(
      .CHAR_ZERO (CHAR_ZERO),
      .CHAR_A    (CHAR_A)
   ) u_lookup (
      .nibble    (sel_nibble),
      .char_code (digit_char)
   );

   assign next_seen = sel_seen || (sel_nibble != 4'd0);
   assign next_char = (sel_blank && !next_seen && !sel_last) ? CHAR_BLANK : digit_char;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_q    <= '0;
         idx_q     <= '0;
         blank_q   <= 1'b0;
         seen_q    <= 1'b0;
         out_valid <= 1'b0;
         out_char  <= 8'd0;
         out_last  <= 1'b0;
      end else if (accept) begin
         word_q    <= ext_in;
         blank_q   <= in_blank;
         seen_q    <= next_seen;
         idx_q     <= IDX_LOAD;
         out_valid <= 1'b1;
         out_char  <= next_char;
         out_last  <= sel_last;
      end else if (advance) begin
         seen_q    <= next_seen;
         out_char  <= next_char;
         out_last  <= sel_last;
         if (idx_q != '0)
            idx_q <= idx_q - IDX_W'(1);
      end else if (last_hs) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hex_word_to_text.sv
// Self-checking bench for hex_word_to_text: directed words from the test plan
// plus randomized words and backpressure, checked against a digit-string model.
module tb_hex_word_to_text;

   logic        clk;
   logic        reset;

   logic        in_valid, in_ready, in_blank, out_valid, out_ready, out_last;
   logic [15:0] in_data;
   logic [7:0]  out_char;

   logic        w6_in_valid, w6_in_ready, w6_in_blank, w6_out_valid, w6_out_ready, w6_out_last;
   logic [5:0]  w6_in_data;
   logic [7:0]  w6_out_char;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   bit   [6:0]  ready_pat = 7'b1001101;

   hex_word_to_text #(.DATA_WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_blank  (in_blank),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_char  (out_char),
      .out_last  (out_last)
   );

   hex_word_to_text #(.DATA_WIDTH(6)) dut6 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (w6_in_valid),
      .in_ready  (w6_in_ready),
      .in_data   (w6_in_data),
      .in_blank  (w6_in_blank),
      .out_valid (w6_out_valid),
      .out_ready (w6_out_ready),
      .out_char  (w6_out_char),
      .out_last  (w6_out_last)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: render the word as a fixed-width hex string, blanking zeros above the top non-zero digit.
   function automatic void build_expect(input logic [15:0] word, input int width, input logic blank);
      int nib = (width + 3) / 4;
      for (int i = nib - 1; i >= 0; i--) begin
         int upper = int'(word) >> (4 * i);
         int d     = upper % 16;
         if (blank && i > 0 && upper == 0)
            exp_q.push_back(8'd0);
         else if (d < 10)
            exp_q.push_back(8'(16 + d));
         else
            exp_q.push_back(8'(33 + d - 10));
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // mode 0: always ready, 1: fixed stall pattern, 2: random stalls
   task automatic applyStimulus(input logic [15:0] word, input logic blank, input int mode, input string tag);
      logic [7:0] held_char;
      logic       held_last;
      bit         stalled;
      int         cyc;
      logic       rdy;
      exp_q.delete();
      build_expect(word, 16, blank);
      @(negedge clk);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = word;
      in_blank = blank;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_blank = 1'($urandom);
      stalled  = 1'b0;
      cyc      = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cyc < 7) ? ready_pat[6 - cyc] : 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         out_ready = rdy;
         checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
         if (stalled) begin
            checkOutput({tag, "_stall_char"}, 32'(out_char), 32'(held_char));
            checkOutput({tag, "_stall_last"}, 32'(out_last), 32'(held_last));
         end
         if (rdy) begin
            checkOutput({tag, "_char"}, 32'(out_char), 32'(exp_q[0]));
            checkOutput({tag, "_last"}, 32'(out_last), 32'(exp_q.size() == 1));
            void'(exp_q.pop_front());
            stalled = 1'b0;
         end else begin
            held_char = out_char;
            held_last = out_last;
            stalled   = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, "_all_chars_seen"}, 32'(exp_q.size()), 32'd0);
      checkOutput({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
      out_ready = 1'b0;
   endtask

   task automatic applyStimulus6(input logic [5:0] word, input logic blank, input string tag);
      exp_q.delete();
      build_expect({10'd0, word}, 6, blank);
      @(negedge clk);
      w6_in_valid  = 1'b1;
      w6_in_data   = word;
      w6_in_blank  = blank;
      w6_out_ready = 1'b1;
      @(negedge clk);
      w6_in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checkOutput({tag, "_valid"}, 32'(w6_out_valid), 32'd1);
         checkOutput({tag, "_char"}, 32'(w6_out_char), 32'(exp_q[k]));
         checkOutput({tag, "_last"}, 32'(w6_out_last), 32'(k == 1));
         @(negedge clk);
      end
      checkOutput({tag, "_idle_valid"}, 32'(w6_out_valid), 32'd0);
   endtask

   initial begin
      logic [15:0] rword;
      in_valid = 1'b0; in_data = '0; in_blank = 1'b0; out_ready = 1'b0;
      w6_in_valid = 1'b0; w6_in_data = '0; w6_in_blank = 1'b0; w6_out_ready = 1'b0;
      reset = 1'b1;

      @(negedge clk);
      @(negedge clk);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_char", 32'(out_char), 32'd0);
      checkOutput("reset_out_last", 32'(out_last), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_w6_out_valid", 32'(w6_out_valid), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("release_in_ready", 32'(in_ready), 32'd1);

      applyStimulus(16'h1A0F, 1'b0, 0, "w1A0F");
      applyStimulus(16'h1A0F, 1'b0, 1, "w1A0F_stall");
      applyStimulus(16'h0000, 1'b1, 0, "w0000_blank");
      applyStimulus(16'h00B3, 1'b1, 0, "w00B3_blank");
      applyStimulus(16'h0000, 1'b0, 0, "w0000_noblank");

      // Back-to-back words with in_valid held across the boundary
      exp_q.delete();
      build_expect(16'hFFFF, 16, 1'b0);
      build_expect(16'h1234, 16, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'hFFFF; in_blank = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_data = 16'h1234;
      for (int k = 0; k < 8; k++) begin
         if (k == 4) in_valid = 1'b0;
         #1;
         checkOutput("b2b_valid", 32'(out_valid), 32'd1);
         checkOutput("b2b_char", 32'(out_char), 32'(exp_q[k]));
         checkOutput("b2b_last", 32'(out_last), 32'(k == 3 || k == 7));
         checkOutput("b2b_in_ready", 32'(in_ready), 32'(k == 3 || k == 7));
         @(negedge clk);
      end
      checkOutput("b2b_idle_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0; out_ready = 1'b0;

      applyStimulus6(6'h2F, 1'b0, "w6_2F");
      applyStimulus6(6'h05, 1'b1, "w6_05_blank");

      // Reset between clock edges after two characters were consumed
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'hABCD; in_blank = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
      checkOutput("async_reset_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      checkOutput("held_reset_valid", 32'(out_valid), 32'd0);
      reset = 1'b0;
      out_ready = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
      applyStimulus(16'h0001, 1'b0, 0, "w0001_after_reset");

      for (int n = 0; n < 16; n++) begin
         rword = 16'($urandom) >> $urandom_range(0, 15);
         applyStimulus(rword, 1'($urandom), 2, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
